sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 112 +++++++++++
 tb/tb_sram_like_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: instruction and data ports share one downstream
// sram-like port, with exactly one transaction outstanding at a time.
module sram_like_arbiter #(
  parameter bit RR_EN = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t r_state;
  owner_t r_owner;
  owner_t r_last_owner;

  logic w_grant_data;
  logic w_sel_data;
  logic w_active;
  logic w_addr_hs;
  logic w_data_hs;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant_data = data_req;
    if (RR_EN && inst_req && data_req)
      w_grant_data = (r_last_owner == OWN_INST);
  end

  // In IDLE the live grant steers the mux; once granted, the owner stays locked.
  assign w_sel_data = (r_state == IDLE) ? w_grant_data : (r_owner == OWN_DATA);
  assign w_active   = resetn && (((r_state == IDLE) && (inst_req || data_req)) ||
                                 (r_state == ADDR));
  assign w_addr_hs  = w_active && m_addr_ok;
  assign w_data_hs  = resetn && (r_state == DATA) && m_data_ok;

  assign m_req   = w_active;
  assign m_wr    = w_sel_data ? data_wr    : inst_wr;
  assign m_size  = w_sel_data ? data_size  : inst_size;
  assign m_addr  = w_sel_data ? data_addr  : inst_addr;
  assign m_wstrb = w_sel_data ? data_wstrb : inst_wstrb;
  assign m_wdata = w_sel_data ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_addr_hs && !w_sel_data;
  assign data_addr_ok = w_addr_hs &&  w_sel_data;
  assign inst_data_ok = w_data_hs && (r_owner == OWN_INST);
  assign data_data_ok = w_data_hs && (r_owner == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_owner      <= OWN_INST;
      r_last_owner <= OWN_INST;
    end else begin
      case (r_state)
        IDLE: begin
          if (inst_req || data_req) begin
            r_owner <= owner_t'(w_grant_data);
            if (m_addr_ok) begin
              r_last_owner <= owner_t'(w_grant_data);
              r_state      <= DATA;
            end else begin
              r_state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            r_last_owner <= r_owner;
            r_state      <= DATA;
          end
        end
        DATA: begin
          if (m_data_ok)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority and a round-robin instance share
// all inputs; cycle vectors plus a response scoreboard check the fixed-priority one.
module tb_sram_like_arbiter;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  localparam logic [38:0] I_PL = {1'b0, 2'd2, 4'hF, 32'h0000_0000};
  localparam logic [38:0] D_PL = {1'b1, 2'd1, 4'h3, 32'hCAFE_0001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, inst_req, inst_wr, data_req, data_wr, m_addr_ok, m_data_ok;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, m_rdata;

  logic        fp_iaok, fp_idok, fp_daok, fp_ddok, fp_mreq, fp_mwr;
  logic [1:0]  fp_msize;
  logic [3:0]  fp_mwstrb;
  logic [31:0] fp_irdata, fp_drdata, fp_maddr, fp_mwdata;
  logic        rr_iaok, rr_idok, rr_daok, rr_ddok, rr_mreq, rr_mwr;
  logic [1:0]  rr_msize;
  logic [3:0]  rr_mwstrb;
  logic [31:0] rr_irdata, rr_drdata, rr_maddr, rr_mwdata;

  sram_like_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(fp_iaok), .inst_data_ok(fp_idok), .inst_rdata(fp_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(fp_daok), .data_data_ok(fp_ddok), .data_rdata(fp_drdata),
    .m_req(fp_mreq), .m_wr(fp_mwr), .m_size(fp_msize), .m_addr(fp_maddr),
    .m_wstrb(fp_mwstrb), .m_wdata(fp_mwdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  sram_like_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(rr_iaok), .inst_data_ok(rr_idok), .inst_rdata(rr_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(rr_daok), .data_data_ok(rr_ddok), .data_rdata(rr_drdata),
    .m_req(rr_mreq), .m_wr(rr_mwr), .m_size(rr_msize), .m_addr(rr_maddr),
    .m_wstrb(rr_mwstrb), .m_wdata(rr_mwdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Response scoreboard: expected responses are queued as stimulus is driven.
  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t sb_q[$];

  always @(negedge clk) begin : sb_mon
    rsp_t e;
    if (fp_idok || fp_ddok) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {62'd0, fp_idok, fp_ddok}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_side", {62'd0, fp_idok, fp_ddok}, e.is_data ? 64'd1 : 64'd2);
        check("rsp_rdata", {32'd0, e.is_data ? fp_drdata : fp_irdata}, {32'd0, e.rdata});
      end
    end
  end

  typedef struct {
    logic        rstn, ireq, dreq, maok, mdok;
    logic [31:0] rdata;
    logic        e_mreq, e_sel, e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic rstn, ireq, dreq, maok, mdok, input logic [31:0] rd,
                              input logic mreq, sel, iaok, daok, idok, ddok);
    vec_t v;
    v.rstn = rstn; v.ireq = ireq; v.dreq = dreq; v.maok = maok; v.mdok = mdok; v.rdata = rd;
    v.e_mreq = mreq; v.e_sel = sel; v.e_iaok = iaok; v.e_daok = daok;
    v.e_idok = idok; v.e_ddok = ddok;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    resetn = v.rstn; inst_req = v.ireq; data_req = v.dreq;
    m_addr_ok = v.maok; m_data_ok = v.mdok; m_rdata = v.rdata;
    if (v.e_idok) sb_q.push_back('{1'b0, v.rdata});
    if (v.e_ddok) sb_q.push_back('{1'b1, v.rdata});
    @(negedge clk);
    check($sformatf("v%0d m_req", idx), {63'd0, fp_mreq}, {63'd0, v.e_mreq});
    if (v.e_mreq) begin
      check($sformatf("v%0d m_addr", idx), {32'd0, fp_maddr}, {32'd0, v.e_sel ? DA : IA});
      check($sformatf("v%0d m_payload", idx), {25'd0, fp_mwr, fp_msize, fp_mwstrb, fp_mwdata},
            {25'd0, v.e_sel ? D_PL : I_PL});
    end
    check($sformatf("v%0d addr_ok", idx), {62'd0, fp_iaok, fp_daok}, {62'd0, v.e_iaok, v.e_daok});
    check($sformatf("v%0d data_ok", idx), {62'd0, fp_idok, fp_ddok}, {62'd0, v.e_idok, v.e_ddok});
    @(posedge clk); #1;
  endtask

  initial begin
    logic        exp_data;
    logic [31:0] rd;
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
    {inst_wr, inst_size, inst_wstrb, inst_wdata} = I_PL; inst_addr = IA;
    {data_wr, data_size, data_wstrb, data_wdata} = D_PL; data_addr = DA;

    //         rstn ireq dreq maok mdok rdata         mreq sel iaok daok idok ddok
    vt.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0)); // in reset
    vt.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0)); // stray addr_ok, idle
    vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0)); // boot fetch accepted
    vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h3C1D_0001,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0)); // conflict: data wins
    vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 1, 32'hDEAD_0008,  0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0)); // inst granted, stalled
    vt.push_back(mk(1, 1, 1, 0, 1, 32'hBAD0_000A,  1, 0, 0, 0, 0, 0)); // lock + stray data_ok
    vt.push_back(mk(1, 1, 1, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 0, 1, 0, 1, 32'h1111_2222,  0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h3333_4444,  0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 0, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0)); // data in ADDR
    vt.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0)); // owner drops req
    vt.push_back(mk(1, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h5555_6666,  0, 0, 0, 0, 0, 0)); // reset in DATA
    vt.push_back(mk(1, 0, 0, 0, 1, 32'h7777_8888,  0, 0, 0, 0, 0, 0)); // late data_ok dropped
    vt.push_back(mk(1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Continuous conflict: round-robin alternates from DATA, fixed priority keeps DATA.
    for (int t = 0; t < 4; t++) begin
      exp_data = (t % 2 == 0);
      rd = 32'hA000_0000 + t;
      inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b0;
      @(negedge clk);
      check($sformatf("rr%0d m_addr", t), {32'd0, rr_maddr}, {32'd0, exp_data ? DA : IA});
      check($sformatf("rr%0d addr_ok", t), {62'd0, rr_iaok, rr_daok},
            {62'd0, !exp_data, exp_data});
      check($sformatf("fp%0d m_addr", t), {32'd0, fp_maddr}, {32'd0, DA});
      @(posedge clk); #1;
      m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = rd;
      sb_q.push_back('{1'b1, rd});
      @(negedge clk);
      check($sformatf("rr%0d m_req", t), {63'd0, rr_mreq}, 64'd0);
      check($sformatf("rr%0d data_ok", t), {62'd0, rr_idok, rr_ddok},
            {62'd0, !exp_data, exp_data});
      check($sformatf("rr%0d rdata", t), {32'd0, exp_data ? rr_drdata : rr_irdata}, {32'd0, rd});
      @(posedge clk); #1;
    end

    inst_req = 1'b0; data_req = 1'b0; m_data_ok = 1'b0;
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("final_idle", {62'd0, fp_mreq, rr_mreq}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
